out_port_capture: RTL and testbench

//  Receive side of the CPU's OUT unit. Watches OUT_unit_output and queues each

---
 rtl/out_port_capture_if.sv | 30 +++
 rtl/out_port_capture.sv | 102 ++++++++++
 tb/tb_out_port_capture.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_port_capture_if.sv
// Capture-port bundle for out_port_capture.
//   master : CPU-side OUT register plus the downstream consumer
//            (drives OUT_unit_output, out_load, change_mode, cap_ready, clr_overflow)
//   slave  : the capture block itself
//            (drives cap_data, cap_valid, count, overflow, drop_cnt)
interface out_port_capture_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] OUT_unit_output;
  logic              out_load;
  logic              change_mode;
  logic [DATA_W-1:0] cap_data;
  logic              cap_valid;
  logic              cap_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clr_overflow;

  modport master (
    output OUT_unit_output, out_load, change_mode, cap_ready, clr_overflow,
    input  cap_data, cap_valid, count, overflow, drop_cnt
  );

  modport slave (
    input  OUT_unit_output, out_load, change_mode, cap_ready, clr_overflow,
    output cap_data, cap_valid, count, overflow, drop_cnt
  );
endinterface

// File: rtl/out_port_capture.sv
// out_port_capture
//   Receive side of the CPU OUT unit. Each capture event queues the current
//   OUT register value into a first-word-fall-through FIFO that a consumer
//   drains with a valid/ready handshake. A capture that finds the FIFO full
//   (and no pop in the same cycle) is dropped and counted; the CPU is never
//   stalled.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low; clears all state immediately
//   bus    : out_port_capture_if.slave
//            in : OUT_unit_output, out_load, change_mode, cap_ready, clr_overflow
//            out: cap_data (FIFO head), cap_valid, count, overflow, drop_cnt
module out_port_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic              clk,
  input logic              reset,
  out_port_capture_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              valid_q;
  logic              load_d;
  logic [DATA_W-1:0] last_val;
  logic              ovf_q;
  logic [7:0]        drop_q;

  logic cap_ev;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // In load mode the event is the delayed pulse, so the OUT register has
  // already taken the new value when it is sampled.
  assign cap_ev = bus.change_mode ? (bus.OUT_unit_output != last_val) : load_d;
  assign full   = (count_q == FULL_CNT);
  assign pop    = valid_q & bus.cap_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push   = cap_ev & (~full | pop);
  assign drop   = cap_ev & full & ~pop;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      load_d   <= 1'b0;
      last_val <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      load_d <= bus.out_load;
      if (cap_ev) last_val <= bus.OUT_unit_output;

      if (push) begin
        mem[wr_ptr] <= bus.OUT_unit_output;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);

      if (bus.clr_overflow) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Head of the FIFO falls through; the storage is reset so cap_data reads 0
  // out of reset. Contents while cap_valid=0 carry no meaning.
  assign bus.cap_data  = mem[rd_ptr];
  assign bus.cap_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_out_port_capture.sv
module tb_out_port_capture;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  out_port_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  out_port_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of captured values plus the bookkeeping values.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  logic              m_load_d;
  logic              m_ovf;
  int                m_drop;
  logic [DATA_W-1:0] obs[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last   = '0;
    m_load_d = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = 0;
  endtask

  task automatic model_edge();
    logic ev;
    logic popd;
    int   n;
    n    = m_q.size();
    ev   = bus.change_mode ? (bus.OUT_unit_output != m_last) : m_load_d;
    popd = (n > 0) && bus.cap_ready;
    if (ev) m_last = bus.OUT_unit_output;
    if (popd) void'(m_q.pop_front());
    if (ev && (n < DEPTH || popd)) m_q.push_back(bus.OUT_unit_output);
    if (bus.clr_overflow) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (ev && n == DEPTH && !popd) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    m_load_d = bus.out_load;
  endtask

  task automatic check_all();
    chk("count", 32'(bus.count), 32'(m_q.size()));
    chk("cap_valid", 32'(bus.cap_valid), 32'(m_q.size() != 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    if (m_q.size() != 0) chk("cap_data", bus.cap_data, m_q[0]);
  endtask

  // One clock: record any handshake, advance model at the edge, check after.
  task automatic step();
    if (bus.cap_valid && bus.cap_ready) obs.push_back(bus.cap_data);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [DATA_W-1:0] v);
    bus.OUT_unit_output = v;
    bus.out_load = 1'b1;
    step();
    bus.out_load = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    bus.cap_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.cap_ready = 1'b0;
  endtask

  initial begin
    reset               = 1'b0;
    bus.OUT_unit_output = '0;
    bus.out_load        = 1'b0;
    bus.change_mode     = 1'b0;
    bus.cap_ready       = 1'b0;
    bus.clr_overflow    = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_cap_data", bus.cap_data, 32'h0);
    check_all();
    #2 reset = 1'b1;

    // 1: three loads, consumer always ready
    bus.cap_ready = 1'b1;
    obs.delete();
    pulse(32'h11);
    pulse(32'h22);
    pulse(32'h33);
    step();
    chk("t1_n", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      chk("t1_d0", obs[0], 32'h11);
      chk("t1_d1", obs[1], 32'h22);
      chk("t1_d2", obs[2], 32'h33);
    end
    chk("t1_count", 32'(bus.count), 32'd0);

    // 2: ten loads into a stalled FIFO
    bus.cap_ready = 1'b0;
    for (int i = 1; i <= 10; i++) pulse(DATA_W'(i));
    chk("t2_count", 32'(bus.count), 32'd8);
    chk("t2_head", bus.cap_data, 32'd1);
    chk("t2_ovf", 32'(bus.overflow), 32'd1);
    chk("t2_drop", 32'(bus.drop_cnt), 32'd2);
    obs.delete();
    drain(9);
    chk("t2_n", 32'(obs.size()), 32'd8);
    for (int i = 0; i < obs.size(); i++) chk("t2_order", obs[i], 32'(i + 1));

    // 3: capture into a full FIFO while popping
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    for (int i = 0; i < 8; i++) pulse(DATA_W'(32'h100 + i));
    bus.OUT_unit_output = 32'hAA;
    bus.out_load = 1'b1;
    step();
    bus.out_load  = 1'b0;
    bus.cap_ready = 1'b1;
    step();
    bus.cap_ready = 1'b0;
    chk("t3_count", 32'(bus.count), 32'd8);
    chk("t3_drop", 32'(bus.drop_cnt), 32'd0);
    chk("t3_ovf", 32'(bus.overflow), 32'd0);
    obs.delete();
    drain(9);
    chk("t3_n", 32'(obs.size()), 32'd8);
    if (obs.size() == 8) chk("t3_last", obs[7], 32'hAA);

    // 4: change-detect mode, load pulses ignored
    bus.change_mode = 1'b1;
    bus.OUT_unit_output = 32'h5;
    for (int i = 0; i < 4; i++) begin
      bus.out_load = 1'($urandom_range(0, 1));
      step();
    end
    bus.OUT_unit_output = 32'h6;
    bus.out_load = 1'b1;
    step();
    bus.out_load = 1'b0;
    step();
    bus.OUT_unit_output = 32'h7;
    step();
    chk("t4_count", 32'(bus.count), 32'd3);
    obs.delete();
    drain(4);
    chk("t4_n", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      chk("t4_d0", obs[0], 32'h5);
      chk("t4_d1", obs[1], 32'h6);
      chk("t4_d2", obs[2], 32'h7);
    end
    bus.change_mode = 1'b0;

    // 5: asynchronous reset between edges
    for (int i = 0; i < 5; i++) pulse(DATA_W'(32'h50 + i));
    chk("t5_pre", 32'(bus.count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.cap_valid), 32'd0);
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    model_reset();
    #2 reset = 1'b1;
    pulse(32'h77);
    chk("t5_after", bus.cap_data, 32'h77);
    chk("t5_after_n", 32'(bus.count), 32'd1);

    // 6: saturation, then clear colliding with a drop
    bus.out_load = 1'b1;
    for (int i = 0; i < 310; i++) begin
      bus.OUT_unit_output = DATA_W'($urandom);
      step();
    end
    chk("t6_sat", 32'(bus.drop_cnt), 32'd255);
    chk("t6_ovf", 32'(bus.overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
    bus.out_load = 1'b0;
    chk("t6_clr_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_clr_drop", 32'(bus.drop_cnt), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.OUT_unit_output = DATA_W'($urandom_range(0, 3));
      bus.out_load        = ($urandom_range(0, 2) == 0);
      bus.cap_ready       = ($urandom_range(0, 3) == 0);
      bus.clr_overflow    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 60) == 0) bus.change_mode = ~bus.change_mode;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
